// File: rtl/regwb_pkg.sv
// Shared widths and the write-back request payload for the register-file write-back arbiter.
package regwb_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regwb_if.sv
// Producer/register-file side bundle of the write-back arbiter.
// REGWB_FWD_EN adds the forwarding lookup signals.
interface regwb_if;
    import regwb_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              Write_enable;
    logic [ADDR_W-1:0] Write_Add;
    logic [DATA_W-1:0] Write_data;
    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]  fifo_count;
`ifdef REGWB_FWD_EN
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, Write_enable, Write_Add, Write_data, pending, fifo_count
`ifdef REGWB_FWD_EN
        , input fwd_addr, output fwd_hit, fwd_data
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, Write_enable, Write_Add, Write_data, pending, fifo_count
`ifdef REGWB_FWD_EN
        , output fwd_addr, input fwd_hit, fwd_data
`endif
    );

endinterface

// File: rtl/regwb_fifo.sv
// Circular queue of ALU write requests with squash-by-address; slots are invalidated on pop.
// REGWB_FWD_EN exports slot data and head pointer for the forwarding search.
module regwb_fifo
    import regwb_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  wb_req_t                       push_req_i,
    input  logic                          pop_i,
    input  logic                          squash_i,
    input  logic [ADDR_W-1:0]             squash_rd_i,
    output wb_req_t                       head_o,
    output logic [CNT_W-1:0]              count_o,
    output logic [DEPTH-1:0]              valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  rd_o
`ifdef REGWB_FWD_EN
    ,
    output logic [DEPTH-1:0][DATA_W-1:0]  data_o,
    output logic [PTR_W-1:0]              rd_ptr_o
`endif
);

    wb_req_t [DEPTH-1:0] slot_q, slot_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Squash hits only entries stored before this edge; the same-edge push lands afterwards.
    always_comb begin
        slot_d   = slot_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (squash_i && slot_q[i].valid && (slot_q[i].rd == squash_rd_i)) begin
                slot_d[i].valid = 1'b0;
            end
        end
        if (pop_i) begin
            slot_d[rd_ptr_q].valid = 1'b0;
        end
        if (push_i) begin
            slot_d[wr_ptr_q] = push_req_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = slot_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_o[i] = slot_q[i].valid;
            rd_o[i]    = slot_q[i].rd;
        end
    end

`ifdef REGWB_FWD_EN
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            data_o[i] = slot_q[i].data;
        end
    end
    assign rd_ptr_o = rd_ptr_q;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges load and ALU results onto the single register-file write port and tracks pending writes.
// REGWB_FWD_EN adds a combinational forwarding lookup (fwd_addr/fwd_hit/fwd_data).
module regfile_wb_arbiter
    import regwb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    regwb_if.slave  bus
);

    wb_req_t                      out_q, out_d;
    wb_req_t                      head;
    wb_req_t                      push_req;
    logic                         push, pop;
    logic                         alu_acc;
    logic [CNT_W-1:0]             count;
    logic [DEPTH-1:0]             fifo_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] fifo_rd;
    logic [NUM_REGS-1:0]          pend;
`ifdef REGWB_FWD_EN
    logic [DEPTH-1:0][DATA_W-1:0] fifo_data;
    logic [PTR_W-1:0]             rd_ptr;
`endif

    assign bus.alu_ready = (count < CNT_W'(DEPTH));
    assign alu_acc       = bus.alu_valid && bus.alu_ready;
    assign push_req      = '{valid: 1'b1, rd: bus.alu_rd, data: bus.alu_data};

    // Load beats queued ALU results; ALU bypasses only when nothing is queued ahead of it.
    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        if (bus.mem_valid) begin
            out_d = '{valid: 1'b1, rd: bus.mem_rd, data: bus.mem_data};
            push  = alu_acc;
        end else if (count != '0) begin
            pop  = 1'b1;
            push = alu_acc;
            if (head.valid) begin
                out_d = head;
            end
        end else if (alu_acc) begin
            out_d = push_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    regwb_fifo u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_req_i  (push_req),
        .pop_i       (pop),
        .squash_i    (bus.mem_valid),
        .squash_rd_i (bus.mem_rd),
        .head_o      (head),
        .count_o     (count),
        .valid_o     (fifo_valid),
        .rd_o        (fifo_rd)
`ifdef REGWB_FWD_EN
        ,
        .data_o      (fifo_data),
        .rd_ptr_o    (rd_ptr)
`endif
    );

    always_comb begin
        pend = '0;
        if (out_q.valid) begin
            pend[out_q.rd] = 1'b1;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (fifo_valid[i]) begin
                pend[fifo_rd[i]] = 1'b1;
            end
        end
    end

    assign bus.Write_enable = out_q.valid;
    assign bus.Write_Add    = out_q.rd;
    assign bus.Write_data   = out_q.data;
    assign bus.pending      = pend;
    assign bus.fifo_count   = count;

`ifdef REGWB_FWD_EN
    logic [PTR_W-1:0]  idx;
    logic [DATA_W-1:0] fwd_data_c;

    // Walk head to tail so the newest matching queued write wins over the output register.
    always_comb begin
        fwd_data_c = '0;
        idx        = '0;
        if (out_q.valid && (out_q.rd == bus.fwd_addr)) begin
            fwd_data_c = out_q.data;
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (fifo_valid[idx] && (fifo_rd[idx] == bus.fwd_addr)) begin
                fwd_data_c = fifo_data[idx];
            end
        end
    end

    assign bus.fwd_hit  = pend[bus.fwd_addr];
    assign bus.fwd_data = fwd_data_c;
`endif

endmodule
